// File: rtl/async_up_counter_if.sv
// Count bus of the ripple up-counter: the live count Q and, when
// ASYNC_UP_COUNTER_TC_EN is defined, the terminal-count flag tc.
`default_nettype none

interface async_up_counter_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] Q;
`ifdef ASYNC_UP_COUNTER_TC_EN
  logic             tc;
`endif

`ifdef ASYNC_UP_COUNTER_TC_EN
  modport master (output Q, output tc);
  modport slave  (input  Q, input  tc);
`else
  modport master (output Q);
  modport slave  (input  Q);
`endif

endinterface

`default_nettype wire

// File: rtl/async_up_counter.sv
// Free-running ripple binary up-counter of WIDTH toggle stages with an async
// active-low clear. Optional tc output enabled by ASYNC_UP_COUNTER_TC_EN.
`default_nettype none

module async_up_counter #(
  parameter int WIDTH = 4
) (
  input  wire                 clk,
  input  wire                 clear,
  async_up_counter_if.master  cnt_if
);

  logic [WIDTH-1:0] count;

  // Each stage is its own flop so that every bit can use a different clock.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic stage_q;
    logic stage_d;

    always_comb begin
      stage_d = ~stage_q;
    end

    if (i == 0) begin : g_lsb
      always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
          stage_q <= 1'b0;
        end else begin
          stage_q <= stage_d;
        end
      end
    end else begin : g_ripple
      // A 1->0 carry out of the stage below clocks this stage.
      always_ff @(negedge count[i-1] or negedge clear) begin
        if (!clear) begin
          stage_q <= 1'b0;
        end else begin
          stage_q <= stage_d;
        end
      end
    end

    assign count[i] = stage_q;
  end

  assign cnt_if.Q = count;

`ifdef ASYNC_UP_COUNTER_TC_EN
  assign cnt_if.tc = clear & (&count);
`endif

endmodule

`default_nettype wire

// File: tb/tb_async_up_counter.sv
// Self-checking bench for async_up_counter at WIDTH=4 and WIDTH=8, driven by
// directed steps plus randomized clear pulses against an edge-count model.
`timescale 1ns/1ps

module tb_async_up_counter;

  logic clk;
  logic clear;

  int checks;
  int failures;
  int edges;

  async_up_counter_if #(.WIDTH(4)) if4 ();
  async_up_counter_if #(.WIDTH(8)) if8 ();

  async_up_counter #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .clear  (clear),
    .cnt_if (if4.master)
  );

  async_up_counter #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .clear  (clear),
    .cnt_if (if8.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // The model is just the number of accepted rising edges since the last clear.
  task automatic check_all(input string tag);
    check_output({tag, "_q4"}, {28'd0, if4.Q}, 32'(edges % 16));
    check_output({tag, "_q8"}, {24'd0, if8.Q}, 32'(edges % 256));
`ifdef ASYNC_UP_COUNTER_TC_EN
    check_output({tag, "_tc"}, {31'd0, if4.tc},
                 {31'd0, (clear === 1'b1) && (edges % 16 == 15)});
`endif
  endtask

  task automatic apply_edge(input string tag);
    @(posedge clk);
    if (clear) edges++;
    @(negedge clk);
    check_all(tag);
  endtask

  // Pulses clear between edges, checks the immediate zero, releases 1 ns before the next edge.
  task automatic pulse_clear(input string tag);
    #2 clear = 1'b0;
    edges = 0;
    #1 check_all({tag, "_now"});
    #1 clear = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    edges    = 0;
    clear    = 1'b0;

    $display("[TB] holding clear low for three periods");
    for (int i = 0; i < 3; i++) begin
      apply_edge("hold_clear");
    end

    #2 clear = 1'b1;
    check_all("release");

    $display("[TB] counting through wrap");
    for (int i = 1; i <= 20; i++) begin
      apply_edge("count");
      if (i == 15) check_output("at_15", {28'd0, if4.Q}, 32'hF);
      if (i == 16) check_output("wrap_16", {28'd0, if4.Q}, 32'h0);
    end
    check_output("after_20", {28'd0, if4.Q}, 32'h4);

    for (int i = 0; i < 6; i++) begin
      apply_edge("to_ten");
    end
    check_output("at_ten", {28'd0, if4.Q}, 32'hA);

    pulse_clear("mid_clear");
    apply_edge("post_clear");
    apply_edge("post_clear");
    check_output("post_clear_2", {28'd0, if4.Q}, 32'h2);

    $display("[TB] full 8-bit cycle");
    pulse_clear("wide_clear");
    for (int i = 1; i <= 256; i++) begin
      apply_edge("wide");
      if (i == 255) check_output("wide_ff", {24'd0, if8.Q}, 32'hFF);
    end
    check_output("wide_wrap", {24'd0, if8.Q}, 32'h00);

    $display("[TB] randomized clear activity");
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0: pulse_clear("rnd_pulse");
        1: begin
          #2 clear = 1'b0;
          edges = 0;
          apply_edge("rnd_held");
          #2 clear = 1'b1;
        end
        default: apply_edge("rnd_count");
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
